vram_dma_responder: RTL and testbench

Port-B memory responder for the Studio II video path. It answers single-byte DMA-out fetch requests from the pixie display generator by reading display RAM through the dual-port RAM's port B. It arbitrates those reads against ROM/cartridge download writes arriving from the ioctl loader. It sits between the pixie front end, the ioctl download bus, and port B of the dpram; the CPU keeps port A.

---
 rtl/vram_dma_responder.sv | 183 ++++++++++++++++++
 tb/tb_vram_dma_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_dma_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_dma_responder: pixie DMA-out fetches on dpram port B, arbitrated       |
// | against ioctl download writes (writes win).             Rev 1.0             |
// +----------------------------------------------------------------------------+
module vram_dma_responder #(
  parameter int            AW        = 12,
  parameter logic [AW-1:0] VRAM_BASE = 12'h900,
  parameter logic [AW-1:0] CART_BASE = 12'h400
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          rd_req,
  input  logic [9:0]    rd_addr,
  output logic [7:0]    rd_data,
  output logic          rd_ack,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [7:0]    dl_index,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  output logic          mem_ce,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  output logic          busy,
  output logic          rd_overrun,
  output logic          dl_overflow,
  output logic          dl_range
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_ACK   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] rd_tgt_q, rd_tgt_d;
  logic          wr_full_q, wr_full_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_ack_q, rd_ack_d;
  logic          mem_ce_q, mem_ce_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_din_q, mem_din_d;
  logic          busy_q, busy_d;
  logic          rd_overrun_q, rd_overrun_d;
  logic          dl_overflow_q, dl_overflow_d;
  logic          dl_range_q, dl_range_d;

  logic [AW-1:0] w_rd_target;
  logic [24:0]   w_dl_full;
  logic          w_dl_in_range;
  logic          w_rd_held;
  logic          w_wr_held;

  assign w_rd_target   = VRAM_BASE + AW'(rd_addr);
  assign w_dl_full     = (dl_index == 8'd0) ? dl_addr : dl_addr + 25'(CART_BASE);
  assign w_dl_in_range = (w_dl_full >> AW) == 25'd0;

  // Registers still occupied after this edge; the releasing cycle admits a new capture.
  assign w_rd_held = rd_pend_q && (state_q != S_RD_ACK);
  assign w_wr_held = wr_full_q && (state_q != S_WR);

  always_comb begin
    rd_pend_d     = w_rd_held;
    rd_tgt_d      = rd_tgt_q;
    wr_full_d     = w_wr_held;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    rd_overrun_d  = rd_overrun_q;
    dl_overflow_d = dl_overflow_q;
    dl_range_d    = dl_range_q;

    if (rd_req) begin
      if (w_rd_held) begin
        rd_overrun_d = 1'b1;
      end else begin
        rd_pend_d = 1'b1;
        rd_tgt_d  = w_rd_target;
      end
    end

    if (dl_wr && dl_active) begin
      if (!w_dl_in_range) begin
        dl_range_d = 1'b1;
      end else if (w_wr_held) begin
        dl_overflow_d = 1'b1;
      end else begin
        wr_full_d = 1'b1;
        wr_addr_d = w_dl_full[AW-1:0];
        wr_data_d = dl_data;
      end
    end

    // Dispatch on next-cycle contents so a fresh capture starts without an idle bubble.
    state_d = S_IDLE;
    case (state_q)
      S_IDLE, S_WR, S_RD_ACK: begin
        if (wr_full_d)      state_d = S_WR;
        else if (rd_pend_d) state_d = S_RD_ISSUE;
        else                state_d = S_IDLE;
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT:  state_d = S_RD_ACK;
      default:    state_d = S_IDLE;
    endcase

    mem_ce_d   = (state_d == S_WR) || (state_d == S_RD_ISSUE);
    mem_wr_d   = (state_d == S_WR);
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (state_d == S_WR) begin
      mem_addr_d = wr_addr_d;
      mem_din_d  = wr_data_d;
    end else if (state_d == S_RD_ISSUE) begin
      mem_addr_d = rd_tgt_d;
    end

    rd_data_d = (state_q == S_RD_WAIT) ? mem_dout : rd_data_q;
    rd_ack_d  = (state_d == S_RD_ACK);
    busy_d    = (state_d != S_IDLE) || rd_pend_d || wr_full_d;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rd_pend_q     <= 1'b0;
      rd_tgt_q      <= '0;
      wr_full_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 8'h00;
      rd_data_q     <= 8'h00;
      rd_ack_q      <= 1'b0;
      mem_ce_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= 8'h00;
      busy_q        <= 1'b0;
      rd_overrun_q  <= 1'b0;
      dl_overflow_q <= 1'b0;
      dl_range_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_pend_q     <= rd_pend_d;
      rd_tgt_q      <= rd_tgt_d;
      wr_full_q     <= wr_full_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_data_q     <= rd_data_d;
      rd_ack_q      <= rd_ack_d;
      mem_ce_q      <= mem_ce_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      busy_q        <= busy_d;
      rd_overrun_q  <= rd_overrun_d;
      dl_overflow_q <= dl_overflow_d;
      dl_range_q    <= dl_range_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_ack      = rd_ack_q;
  assign mem_ce      = mem_ce_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign busy        = busy_q;
  assign rd_overrun  = rd_overrun_q;
  assign dl_overflow = dl_overflow_q;
  assign dl_range    = dl_range_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_dma_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vram_dma_responder: directed and random stimulus against a port-B       |
// | scheduling model with an emulated dpram.                  Rev 1.0           |
// +----------------------------------------------------------------------------+
module tb_vram_dma_responder;

  logic        clk;
  logic        reset;
  logic        rd_req;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_ack;
  logic        dl_active;
  logic        dl_wr;
  logic [7:0]  dl_index;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        mem_ce;
  logic        mem_wr;
  logic [11:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        busy;
  logic        rd_overrun;
  logic        dl_overflow;
  logic        dl_range;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  vram_dma_responder dut (
    .clk_sys     (clk),
    .reset       (reset),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ack      (rd_ack),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_index    (dl_index),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .mem_ce      (mem_ce),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .busy        (busy),
    .rd_overrun  (rd_overrun),
    .dl_overflow (dl_overflow),
    .dl_range    (dl_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 29) ^ (i >> 3) ^ 8'h5A);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  // Emulated dpram port B: registered read, one-cycle latency.
  logic [7:0] ram [4096];
  bit         ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] = init_byte(i);
      ram_ready = 1'b1;
    end
    if (mem_ce && mem_wr) ram[mem_addr] = mem_din;
    if (mem_ce && !mem_wr) mem_dout <= ram[mem_addr];
  end

  // Model: port B as a timeline. A write occupies one cycle, a read three
  // (issue, wait, ack). m_free is the first cycle a new access may start.
  logic [7:0]  m_mem [4096];
  bit          m_ready = 1'b0;
  int          m_free;
  bit          m_rd_v, m_wr_v;
  int          m_rd_iss, m_wr_at;
  logic [11:0] m_rd_a, m_wr_a;
  logic [7:0]  m_wr_d;
  logic [24:0] m_full;
  logic [7:0]  e_rdata, e_din;
  logic [11:0] e_addr;
  logic        e_ack, e_ce, e_wr, e_busy, e_ovr, e_ovf, e_rng;

  task automatic model_reset();
    m_free = 0; m_rd_v = 0; m_wr_v = 0; m_rd_iss = -1; m_wr_at = -1;
    e_rdata = 8'h00; e_din = 8'h00; e_addr = 12'h000;
    e_ack = 0; e_ce = 0; e_wr = 0; e_busy = 0; e_ovr = 0; e_ovf = 0; e_rng = 0;
  endtask

  task automatic model_step();
    if (m_rd_v && m_rd_iss >= 0 && t == m_rd_iss + 2) m_rd_v = 0;
    if (m_wr_v && m_wr_at == t) begin
      m_mem[m_wr_a] = m_wr_d;
      m_wr_v = 0;
    end
    if (rd_req) begin
      if (m_rd_v) e_ovr = 1;
      else begin
        m_rd_v = 1; m_rd_iss = -1;
        m_rd_a = 12'((32'h900 + 32'(rd_addr)) % 4096);
      end
    end
    if (dl_wr && dl_active) begin
      m_full = (dl_index == 8'd0) ? dl_addr : dl_addr + 25'h400;
      if (m_full >= 25'd4096) e_rng = 1;
      else if (m_wr_v) e_ovf = 1;
      else begin
        m_wr_v = 1; m_wr_at = -1; m_wr_a = m_full[11:0]; m_wr_d = dl_data;
      end
    end
    if (m_free <= t + 1) begin
      if (m_wr_v && m_wr_at < 0) begin
        m_wr_at = t + 1; m_free = t + 2;
      end else if (m_rd_v && m_rd_iss < 0) begin
        m_rd_iss = t + 1; m_free = t + 4;
      end
    end
    e_wr  = m_wr_v && m_wr_at == t + 1;
    e_ce  = e_wr || (m_rd_v && m_rd_iss == t + 1);
    e_ack = m_rd_v && m_rd_iss >= 0 && m_rd_iss + 2 == t + 1;
    if (e_wr) begin
      e_addr = m_wr_a; e_din = m_wr_d;
    end else if (e_ce) begin
      e_addr = m_rd_a;
    end
    if (e_ack) e_rdata = m_mem[m_rd_a];
    e_busy = (m_free > t + 1) || m_rd_v || m_wr_v;
  endtask

  always @(negedge clk) begin
    if (!m_ready) begin
      for (int i = 0; i < 4096; i++) m_mem[i] = init_byte(i);
      model_reset();
      m_ready = 1'b1;
    end
    if (reset) model_reset();
    chk("rd_data",     32'(rd_data),     32'(e_rdata));
    chk("rd_ack",      32'(rd_ack),      32'(e_ack));
    chk("mem_ce",      32'(mem_ce),      32'(e_ce));
    chk("mem_wr",      32'(mem_wr),      32'(e_wr));
    chk("mem_addr",    32'(mem_addr),    32'(e_addr));
    chk("mem_din",     32'(mem_din),     32'(e_din));
    chk("busy",        32'(busy),        32'(e_busy));
    chk("rd_overrun",  32'(rd_overrun),  32'(e_ovr));
    chk("dl_overflow", 32'(dl_overflow), 32'(e_ovf));
    chk("dl_range",    32'(dl_range),    32'(e_rng));
    if (!reset) model_step();
    t++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int acks;

  initial begin
    reset = 1; rd_req = 0; rd_addr = '0; dl_active = 0; dl_wr = 0;
    dl_index = '0; dl_addr = '0; dl_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_reset_rd_data", 32'(rd_data), 32'h0);
    chk("lit_reset_outs", 32'({rd_ack, mem_ce, mem_wr, busy, rd_overrun, dl_overflow, dl_range}), 32'h0);
    chk("lit_reset_addr_din", 32'({mem_addr, mem_din}), 32'h0);
    @(posedge clk); #1 reset = 0;

    // Preload 0x905 through a system-ROM download write
    dl_active = 1; dl_index = 8'd0; dl_addr = 25'h905; dl_data = 8'hA5; dl_wr = 1;
    tick(); dl_wr = 0;
    repeat (2) tick();

    // Uncontended read
    rd_req = 1; rd_addr = 10'd5; tick(); rd_req = 0;
    @(negedge clk);
    chk("lit_rd_issue_ce", 32'({mem_ce, mem_wr}), 32'b10);
    chk("lit_rd_issue_addr", 32'(mem_addr), 32'h905);
    tick(); @(negedge clk);
    chk("lit_rd_wait_ack", 32'(rd_ack), 32'h0);
    tick(); @(negedge clk);
    chk("lit_rd_ack", 32'(rd_ack), 32'h1);
    chk("lit_rd_data", 32'(rd_data), 32'hA5);
    tick();

    // Cartridge write
    dl_index = 8'd1; dl_addr = 25'h10; dl_data = 8'h3C; dl_wr = 1; tick(); dl_wr = 0;
    @(negedge clk);
    chk("lit_cart_wr", 32'({mem_ce, mem_wr}), 32'b11);
    chk("lit_cart_addr", 32'(mem_addr), 32'h410);
    chk("lit_cart_din", 32'(mem_din), 32'h3C);
    chk("lit_cart_range", 32'(dl_range), 32'h0);
    tick();

    // Write and read captured together
    dl_index = 8'd0; dl_addr = 25'h0AB; dl_data = 8'h77; dl_wr = 1;
    rd_req = 1; rd_addr = 10'd0; tick(); dl_wr = 0; rd_req = 0;
    @(negedge clk);
    chk("lit_both_wr", 32'({mem_wr, mem_addr}), 32'h10AB);
    tick(); @(negedge clk);
    chk("lit_both_rd_issue", 32'({mem_ce, mem_wr, mem_addr}), 32'h2900);
    tick(); @(negedge clk);
    chk("lit_both_ack3", 32'(rd_ack), 32'h0);
    tick(); @(negedge clk);
    chk("lit_both_ack4", 32'(rd_ack), 32'h1);
    tick();

    // Overrun: second request one cycle into an outstanding read
    rd_req = 1; rd_addr = 10'd7; tick(); rd_addr = 10'd8;
    @(negedge clk);
    chk("lit_ovr_addr", 32'(mem_addr), 32'h907);
    tick(); rd_req = 0;
    acks = 0;
    @(negedge clk);
    chk("lit_ovr_flag", 32'(rd_overrun), 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (rd_ack) acks++;
      if (i == 1) chk("lit_ovr_data", 32'(rd_data), 32'(init_byte(12'h907)));
      tick(); @(negedge clk);
    end
    chk("lit_ovr_one_ack", 32'(acks), 32'd1);
    tick();

    // Out-of-range cartridge write, then overflow while a read owns port B
    dl_index = 8'd1; dl_addr = 25'hC00; dl_data = 8'hEE; dl_wr = 1; tick(); dl_wr = 0;
    @(negedge clk);
    chk("lit_range_no_ce", 32'(mem_ce), 32'h0);
    chk("lit_range_flag", 32'(dl_range), 32'h1);
    tick();
    rd_req = 1; rd_addr = 10'd3; tick(); rd_req = 0;
    dl_index = 8'd0; dl_addr = 25'h20; dl_data = 8'h11; dl_wr = 1; tick();
    dl_addr = 25'h21; dl_data = 8'h22;
    @(negedge clk);
    chk("lit_ovf_before", 32'(dl_overflow), 32'h0);
    tick(); dl_wr = 0;
    @(negedge clk);
    chk("lit_ovf_flag", 32'(dl_overflow), 32'h1);
    tick(); @(negedge clk);
    chk("lit_ovf_first_wr", 32'({mem_wr, mem_addr, mem_din}), 32'h102011);
    tick();

    // Reset during RD_WAIT
    rd_req = 1; rd_addr = 10'd9; tick(); rd_req = 0;
    tick(); #2 reset = 1;
    @(negedge clk);
    chk("lit_rst_outs", 32'({rd_ack, mem_ce, mem_wr, busy, rd_overrun, dl_overflow, dl_range}), 32'h0);
    chk("lit_rst_regs", 32'({rd_data, mem_addr, mem_din}), 32'h0);
    tick(); reset = 0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rd_ack) acks++;
      tick();
    end
    chk("lit_rst_no_ack", 32'(acks), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599, 0) == 0) begin
        rd_req = 0; dl_wr = 0; reset = 1;
        tick();
        reset = 0;
      end else begin
        rd_req    = ($urandom_range(3, 0) == 0);
        rd_addr   = 10'($urandom);
        dl_active = ($urandom_range(7, 0) != 0);
        dl_wr     = ($urandom_range(3, 0) == 0);
        dl_index  = ($urandom_range(1, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
        case ($urandom_range(3, 0))
          0:       dl_addr = 25'($urandom);
          1:       dl_addr = 25'h0B00 + 25'($urandom_range(511, 0));
          default: dl_addr = 25'($urandom_range(4095, 0));
        endcase
        dl_data = 8'($urandom);
        tick();
      end
    end
    rd_req = 0; dl_wr = 0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
